bus_sequencer: RTL and testbench
================================

Name: bus_sequencer

Overview:
- Control-unit sequencer for the 32-bit single-bus datapath.
- Each cycle it drives exactly one 24-bit one-hot bus-drive select into the bus multiplexer, plus the register load strobes, memory read request and ALU capture strobes.
- Runs fetch (T0-T2) and then a per-class execute sequence (T3-T7) from a pre-decoded instruction class.
- Stalls on memory reads until the memory handshake completes.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; leaves IDLE.
- op_class  input  3  decoded IR class: 0 NOP, 1 ALU_RR, 2 ALU_RI, 3 LOAD, 4 LDI, 5 MFHI, 6 MFLO, 7 HALT.
- ra, rb, rc  input  4 each  IR register fields.
- mem_ready  input  1  memory read data valid this cycle.
- step  input  1  single-step advance pulse (used only with the optional feature).
- bus_sel  output  24  one-hot drive select. Bits 0-15 R0-R15, 16 HI, 17 LO, 18 Zhi, 19 Zlo, 20 PC, 21 MDR, 22 InPort, 23 C sign-extended.
- reg_in  output  16  one-hot general register load.
- pc_in, ir_in, mar_in, mdr_in, y_in, z_in, inc_pc, mem_read  output  1 each  load/control strobes.
- busy  output  1  high in any state other than IDLE and HALT.
- halted  output  1  high in HALT.
- instr_count  output  CNT_W  retired instructions.

Behaviour:
- States: IDLE, T0..T7, HALT. Outputs are a Moore decode of the state register and the ra/rb/rc inputs.
- Reset (async, any time including mid-instruction):
  - State goes to IDLE.
  - bus_sel, reg_in, all strobes, busy, halted = 0.
  - instr_count = 0.
- IDLE: all outputs 0. start=1 -> T0. start in any other state is ignored.
- T0: bus_sel[20] (PC), mar_in, inc_pc, z_in -> T1.
- T1: bus_sel[19] (Zlo), pc_in and mem_read asserted.
  - pc_in is high only on the first T1 cycle.
  - mem_read is held high while mem_ready=0.
  - mdr_in is asserted in the cycle mem_ready=1; the state then moves to T2.
  - If mem_ready=1 already on the first T1 cycle, T1 lasts exactly one cycle.
- T2: bus_sel[21] (MDR), ir_in -> T3. op_class and ra/rb/rc are valid from T3 onward.
- T3, by op_class:
  - NOP: retire, -> T0.
  - ALU_RR, ALU_RI, LOAD, LDI: bus_sel[rb], y_in -> T4.
  - MFHI: bus_sel[16], reg_in[ra], retire -> T0.
  - MFLO: bus_sel[17], reg_in[ra], retire -> T0.
  - HALT: -> HALT, with no bus drive.
- T4: ALU_RR drives bus_sel[rc]; all other classes drive bus_sel[23] (C). z_in is asserted -> T5.
- T5: bus_sel[19] (Zlo).
  - LOAD: mar_in -> T6.
  - Other classes: reg_in[ra], retire -> T0.
- T6 (LOAD): bus_sel=0, mem_read=1 while mem_ready=0. mdr_in in the mem_ready=1 cycle, then -> T7.
- T7 (LOAD): bus_sel[21], reg_in[ra], retire -> T0.
- HALT: halted=1, all other outputs 0; stays in HALT until reset.
- Retire: instr_count increments by 1 on the cycle the instruction leaves its last state. It wraps modulo 2^CNT_W. HALT does not count.
- Invariants:
  - bus_sel is 0 or exactly one-hot in every cycle.
  - reg_in is 0 or one-hot.
  - Every cycle is exactly 1 clock except T1 and T6, which stretch with mem_ready.
  - Latency (mem_ready tied high): NOP 4 cycles; MFHI/MFLO 4; ALU_RR/ALU_RI/LDI 6; LOAD 8.

Optional Feature:
- Macro: BUS_SEQ_SINGLE_STEP_EN.
- Defined:
  - After every retire the sequencer returns to IDLE instead of T0.
  - A step pulse in IDLE (or a start pulse) then enters T0.
  - busy=0 while waiting.
- Undefined:
  - The step input is ignored; retire goes directly to T0.

Test Plan:
- Reset held 3 cycles, then released with start pulsed, mem_ready=1, op_class=1, ra=3, rb=1, rc=2:
  - bus_sel sequence is 0x100000, 0x080000, 0x200000, 0x000002, 0x000004, 0x080000.
  - reg_in=0x0008 in T5; instr_count=1.
- LOAD (op_class=3, ra=5, rb=4) with mem_ready low for 3 cycles in both T1 and T6:
  - T1 and T6 each last 4 cycles; mdr_in pulses once in each.
  - T7 has bus_sel=0x200000 and reg_in=0x0020; total 14 cycles.
- MFHI with ra=15 -> T3 has bus_sel=0x010000 and reg_in=0x8000; 4-cycle instruction.
- HALT -> halted=1 and all other outputs 0 for 20 cycles; start pulses are ignored.
- Reset asserted mid-T4 of an ALU_RI -> the same cycle shows bus_sel=0, z_in=0, state IDLE, instr_count=0.
- CNT_W=4, 16 NOPs retired -> instr_count wraps to 0.
- With BUS_SEQ_SINGLE_STEP_EN defined -> after a NOP the block sits in IDLE until step=1.

Source files
------------

// File: rtl/bus_sequencer_if.sv
// Handshake/bus bundle between the control sequencer and the single-bus datapath.
// master = sequencer side, slave = datapath/memory side.
interface bus_sequencer_if;
    logic        start;
    logic [2:0]  op_class;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rc;
    logic        mem_ready;
    logic        step;
    logic [23:0] bus_sel;
    logic [15:0] reg_in;
    logic        pc_in;
    logic        ir_in;
    logic        mar_in;
    logic        mdr_in;
    logic        y_in;
    logic        z_in;
    logic        inc_pc;
    logic        mem_read;
    logic        busy;
    logic        halted;

    modport master (
        input  start, op_class, ra, rb, rc, mem_ready, step,
        output bus_sel, reg_in, pc_in, ir_in, mar_in, mdr_in, y_in, z_in, inc_pc, mem_read,
               busy, halted
    );

    modport slave (
        output start, op_class, ra, rb, rc, mem_ready, step,
        input  bus_sel, reg_in, pc_in, ir_in, mar_in, mdr_in, y_in, z_in, inc_pc, mem_read,
               busy, halted
    );
endinterface

// File: rtl/bus_sequencer.sv
// Fetch/execute control sequencer for the 32-bit single-bus datapath.
// Optional BUS_SEQ_SINGLE_STEP_EN: each retire parks in idle until step/start.
module bus_sequencer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    bus_sequencer_if.master    bus,
    output logic [CNT_W-1:0]   instr_count
);

    typedef enum logic [3:0] {
        StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalt
    } state_e;

    localparam logic [2:0] ClsNop  = 3'd0;
    localparam logic [2:0] ClsAluRr = 3'd1;
    localparam logic [2:0] ClsLoad = 3'd3;
    localparam logic [2:0] ClsMfhi = 3'd5;
    localparam logic [2:0] ClsMflo = 3'd6;
    localparam logic [2:0] ClsHalt = 3'd7;

`ifdef BUS_SEQ_SINGLE_STEP_EN
    localparam state_e RetireSt = StIdle;
    logic kick;
    assign kick = bus.start | bus.step;
`else
    localparam state_e RetireSt = StT0;
    logic kick;
    logic unused_step;
    assign kick        = bus.start;
    assign unused_step = bus.step;
`endif

    state_e           state_q;
    logic             t1_wait_q;  // set once T1 has stalled, so pc_in fires only on its first cycle
    logic [CNT_W-1:0] cnt_q;
    logic             retire;

    assign retire = (state_q == StT3 && (bus.op_class == ClsNop || bus.op_class == ClsMfhi ||
                                         bus.op_class == ClsMflo)) ||
                    (state_q == StT5 && bus.op_class != ClsLoad) ||
                    (state_q == StT7);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            t1_wait_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            t1_wait_q <= 1'b0;
            if (retire) cnt_q <= cnt_q + 1'b1;
            unique case (state_q)
                StIdle: if (kick) state_q <= StT0;
                StT0:   state_q <= StT1;
                StT1: begin
                    if (bus.mem_ready) state_q <= StT2;
                    else               t1_wait_q <= 1'b1;
                end
                StT2:   state_q <= StT3;
                StT3: begin
                    if (retire)                      state_q <= RetireSt;
                    else if (bus.op_class == ClsHalt) state_q <= StHalt;
                    else                             state_q <= StT4;
                end
                StT4:   state_q <= StT5;
                StT5:   state_q <= retire ? RetireSt : StT6;
                StT6:   if (bus.mem_ready) state_q <= StT7;
                StT7:   state_q <= RetireSt;
                StHalt: state_q <= StHalt;
                default: state_q <= StIdle;
            endcase
        end
    end

    logic [23:0] bus_sel;
    logic [15:0] reg_in;
    logic pc_in, ir_in, mar_in, mdr_in, y_in, z_in, inc_pc, mem_read;

    always_comb begin
        bus_sel  = '0;
        reg_in   = '0;
        pc_in    = 1'b0;
        ir_in    = 1'b0;
        mar_in   = 1'b0;
        mdr_in   = 1'b0;
        y_in     = 1'b0;
        z_in     = 1'b0;
        inc_pc   = 1'b0;
        mem_read = 1'b0;
        unique case (state_q)
            StT0: begin
                bus_sel[20] = 1'b1;
                mar_in      = 1'b1;
                inc_pc      = 1'b1;
                z_in        = 1'b1;
            end
            StT1: begin
                bus_sel[19] = 1'b1;
                pc_in       = ~t1_wait_q;
                mem_read    = 1'b1;
                mdr_in      = bus.mem_ready;
            end
            StT2: begin
                bus_sel[21] = 1'b1;
                ir_in       = 1'b1;
            end
            StT3: begin
                unique case (bus.op_class)
                    ClsNop, ClsHalt: ;
                    ClsMfhi: begin
                        bus_sel[16]    = 1'b1;
                        reg_in[bus.ra] = 1'b1;
                    end
                    ClsMflo: begin
                        bus_sel[17]    = 1'b1;
                        reg_in[bus.ra] = 1'b1;
                    end
                    default: begin
                        bus_sel[bus.rb] = 1'b1;
                        y_in            = 1'b1;
                    end
                endcase
            end
            StT4: begin
                if (bus.op_class == ClsAluRr) bus_sel[bus.rc] = 1'b1;
                else                          bus_sel[23]     = 1'b1;
                z_in = 1'b1;
            end
            StT5: begin
                bus_sel[19] = 1'b1;
                if (bus.op_class == ClsLoad) mar_in         = 1'b1;
                else                         reg_in[bus.ra] = 1'b1;
            end
            StT6: begin
                mem_read = 1'b1;
                mdr_in   = bus.mem_ready;
            end
            StT7: begin
                bus_sel[21]    = 1'b1;
                reg_in[bus.ra] = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.bus_sel  = bus_sel;
    assign bus.reg_in   = reg_in;
    assign bus.pc_in    = pc_in;
    assign bus.ir_in    = ir_in;
    assign bus.mar_in   = mar_in;
    assign bus.mdr_in   = mdr_in;
    assign bus.y_in     = y_in;
    assign bus.z_in     = z_in;
    assign bus.inc_pc   = inc_pc;
    assign bus.mem_read = mem_read;
    assign bus.busy     = (state_q != StIdle) && (state_q != StHalt);
    assign bus.halted   = (state_q == StHalt);
    assign instr_count  = cnt_q;

endmodule

// File: tb/tb_bus_sequencer.sv
// Bench for bus_sequencer: per-instruction expected cycle lists built from the
// instruction-class rules, replayed against the DUT with random waits and stray pulses.
module tb_bus_sequencer;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [CW-1:0] instr_count;

    bus_sequencer_if bus ();

    bus_sequencer #(.CNT_W(CW)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .instr_count (instr_count)
    );

    always #5 clock = ~clock;

    localparam logic [7:0] SPC  = 8'h80, SIR = 8'h40, SMAR = 8'h20, SMDR = 8'h10;
    localparam logic [7:0] SY   = 8'h08, SZ  = 8'h04, SINC = 8'h02, SMRD = 8'h01;

    typedef struct {
        logic        start, step, rdy;
        logic [2:0]  cls;
        logic [3:0]  ra, rb, rc;
        logic [23:0] bsel;
        logic [15:0] regi;
        logic [7:0]  strb;
        logic        busy, halted, retire, kill, wrap;
        int          ph;
    } cyc_t;

    cyc_t          q[$];
    int            n_total = 0;
    int            n_pass  = 0;
    logic [CW-1:0] exp_cnt;
    bit            in_idle;
    bit            mark_wrap;
    logic [2:0]    c_cls;
    logic [3:0]    c_ra, c_rb, c_rc;

    task automatic chk(input string name, input int ph, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s (phase %0d): got %h expected %h", name, ph, obs, exp);
    endtask

    task automatic push(input int ph, input logic [23:0] b, input logic [15:0] r,
                        input logic [7:0] s, input int rdy, input bit ret, input bit kill);
        cyc_t e;
        e.start = 1'($urandom_range(0, 1));
`ifdef BUS_SEQ_SINGLE_STEP_EN
        e.step  = 1'b0;
`else
        e.step  = 1'($urandom_range(0, 1));
`endif
        e.rdy    = (rdy == 2) ? 1'($urandom_range(0, 1)) : rdy[0];
        e.cls    = c_cls;
        e.ra     = c_ra;
        e.rb     = c_rb;
        e.rc     = c_rc;
        e.bsel   = b;
        e.regi   = r;
        e.strb   = s;
        e.busy   = 1'b1;
        e.halted = 1'b0;
        e.retire = ret;
        e.kill   = kill;
        e.wrap   = mark_wrap;
        e.ph     = ph;
        mark_wrap = 1'b0;
        q.push_back(e);
    endtask

    task automatic push_quiet(input int ph, input logic st, input logic sp, input logic hlt);
        cyc_t e;
        e.start  = st;
        e.step   = sp;
        e.rdy    = 1'($urandom_range(0, 1));
        e.cls    = c_cls;
        e.ra     = c_ra;
        e.rb     = c_rb;
        e.rc     = c_rc;
        e.bsel   = '0;
        e.regi   = '0;
        e.strb   = '0;
        e.busy   = 1'b0;
        e.halted = hlt;
        e.retire = 1'b0;
        e.kill   = 1'b0;
        e.wrap   = mark_wrap;
        e.ph     = ph;
        mark_wrap = 1'b0;
        q.push_back(e);
    endtask

    task automatic retired();
`ifdef BUS_SEQ_SINGLE_STEP_EN
        in_idle = 1'b1;
`endif
    endtask

    // Expected cycle list of one instruction; ph 8 = idle, ph 9 = halt.
    task automatic add_instr(input logic [2:0] cls, input logic [3:0] ra, input logic [3:0] rb,
                             input logic [3:0] rc, input int w1, input int w6, input bit kill);
        c_cls = cls; c_ra = ra; c_rb = rb; c_rc = rc;
        if (in_idle) begin
`ifdef BUS_SEQ_SINGLE_STEP_EN
            repeat ($urandom_range(0, 2)) push_quiet(8, 1'b0, 1'b0, 1'b0);
            push_quiet(8, 1'b0, 1'b1, 1'b0);
`else
            push_quiet(8, 1'b1, 1'b0, 1'b0);
`endif
            in_idle = 1'b0;
        end
        push(0, 24'h100000, 16'h0, SMAR | SINC | SZ, 2, 1'b0, 1'b0);
        for (int i = 0; i <= w1; i++)
            push(1, 24'h080000, 16'h0, ((i == 0) ? SPC : 8'h0) | SMRD | ((i == w1) ? SMDR : 8'h0),
                 (i == w1) ? 1 : 0, 1'b0, 1'b0);
        push(2, 24'h200000, 16'h0, SIR, 2, 1'b0, 1'b0);
        case (cls)
            3'd0: begin push(3, 24'h0, 16'h0, 8'h0, 2, 1'b1, 1'b0); retired(); end
            3'd5: begin push(3, 24'h010000, 16'd1 << ra, 8'h0, 2, 1'b1, 1'b0); retired(); end
            3'd6: begin push(3, 24'h020000, 16'd1 << ra, 8'h0, 2, 1'b1, 1'b0); retired(); end
            3'd7: begin
                push(3, 24'h0, 16'h0, 8'h0, 2, 1'b0, 1'b0);
                for (int i = 0; i < 20; i++) push_quiet(9, 1'(i % 2), 1'b0, 1'b1);
            end
            default: begin
                push(3, 24'd1 << rb, 16'h0, SY, 2, 1'b0, 1'b0);
                push(4, (cls == 3'd1) ? (24'd1 << rc) : 24'h800000, 16'h0, SZ, 2, 1'b0, kill);
                if (cls == 3'd3) begin
                    push(5, 24'h080000, 16'h0, SMAR, 2, 1'b0, 1'b0);
                    for (int i = 0; i <= w6; i++)
                        push(6, 24'h0, 16'h0, SMRD | ((i == w6) ? SMDR : 8'h0),
                             (i == w6) ? 1 : 0, 1'b0, 1'b0);
                    push(7, 24'h200000, 16'd1 << ra, 8'h0, 2, 1'b1, 1'b0);
                end else begin
                    push(5, 24'h080000, 16'd1 << ra, 8'h0, 2, 1'b1, 1'b0);
                end
                retired();
            end
        endcase
    endtask

    function automatic logic [7:0] strobes();
        return {bus.pc_in, bus.ir_in, bus.mar_in, bus.mdr_in, bus.y_in, bus.z_in, bus.inc_pc,
                bus.mem_read};
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, " bus_sel"}, 8, 32'(bus.bus_sel), 32'h0);
        chk({tag, " reg_in"}, 8, 32'(bus.reg_in), 32'h0);
        chk({tag, " strobes"}, 8, 32'(strobes()), 32'h0);
        chk({tag, " busy"}, 8, 32'(bus.busy), 32'h0);
        chk({tag, " halted"}, 8, 32'(bus.halted), 32'h0);
        chk({tag, " instr_count"}, 8, 32'(instr_count), 32'h0);
    endtask

    task automatic run_queue();
        cyc_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            bus.start     = e.start;
            bus.step      = e.step;
            bus.mem_ready = e.rdy;
            bus.op_class  = e.cls;
            bus.ra        = e.ra;
            bus.rb        = e.rb;
            bus.rc        = e.rc;
            if (e.kill) begin
                #1 reset = 1'b1;
                #1 check_zero("midreset");
                q.delete();
                bus.start = 1'b0;
                bus.step  = 1'b0;
                @(posedge clock);
                @(posedge clock);
                #1 reset = 1'b0;
                exp_cnt = '0;
                in_idle = 1'b1;
                break;
            end
            @(negedge clock);
            chk("bus_sel", e.ph, 32'(bus.bus_sel), 32'(e.bsel));
            chk("reg_in", e.ph, 32'(bus.reg_in), 32'(e.regi));
            chk("strobes", e.ph, 32'(strobes()), 32'(e.strb));
            chk("busy", e.ph, 32'(bus.busy), 32'(e.busy));
            chk("halted", e.ph, 32'(bus.halted), 32'(e.halted));
            chk("instr_count", e.ph, 32'(instr_count), 32'(exp_cnt));
            if (e.wrap) chk("count_wrap", e.ph, 32'(instr_count), 32'h0);
            if (e.retire) exp_cnt = exp_cnt + 1'b1;
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.step = 1'b0; bus.mem_ready = 1'b0;
        bus.op_class = '0; bus.ra = '0; bus.rb = '0; bus.rc = '0;
        exp_cnt = '0; in_idle = 1'b1; mark_wrap = 1'b0;
        c_cls = '0; c_ra = '0; c_rb = '0; c_rc = '0;

        repeat (3) begin
            @(negedge clock);
            check_zero("reset");
        end
        @(posedge clock);
        #1 reset = 1'b0;

        add_instr(3'd1, 4'd3, 4'd1, 4'd2, 0, 0, 1'b0);
        add_instr(3'd3, 4'd5, 4'd4, 4'd0, 3, 3, 1'b0);
        add_instr(3'd5, 4'd15, 4'd0, 4'd0, 0, 0, 1'b0);
        repeat (30)
            add_instr(3'($urandom_range(0, 6)), 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
        add_instr(3'd2, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'd0, 0, 0, 1'b1);
        run_queue();

        repeat (16)
            add_instr(3'd0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)), $urandom_range(0, 2), 0, 1'b0);
        mark_wrap = 1'b1;
        add_instr(3'd7, 4'd0, 4'd0, 4'd0, 0, 0, 1'b0);
        run_queue();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
